// File: rtl/wb_store_ctrl.sv
// Write-back sequencer: counts stage-1 rows or PE_ELEMENTS stage-2 scalars and
// issues one registered store per completed row, stalling the PE pipe and yielding the DMEM port.
module wb_store_ctrl #(
    parameter int  PE_ELEMENTS     = 4,
    parameter int  DMEM_DEPTH      = 1024,
    parameter int  ROW_CNT_W       = 16,
    localparam int DRAM_ADDR_WIDTH = $clog2(DMEM_DEPTH / PE_ELEMENTS),
    localparam int ELEM_W          = $clog2(PE_ELEMENTS + 1)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       start,
    input  logic                       mode,
    input  logic [DRAM_ADDR_WIDTH-1:0] base_addr,
    input  logic [ROW_CNT_W-1:0]       num_rows,
    input  logic                       result_stage_1_valid,
    input  logic                       result_stage_2_valid,
    input  logic                       ld_req,
    output logic                       ld_gnt,
    output logic                       store_result,
    output logic [DRAM_ADDR_WIDTH-1:0] write_addr,
    output logic                       pipe_stall,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);

    typedef enum logic [1:0] {IDLE, COLLECT, STORE, FIN} state_t;

    localparam logic             MODE_RED  = 1'b1;
    localparam logic [ELEM_W-1:0] ELEM_LAST = ELEM_W'(PE_ELEMENTS - 1);

    state_t                     state, state_nx;
    logic                       mode_q;
    logic [DRAM_ADDR_WIDTH-1:0] base_q;
    logic [ROW_CNT_W-1:0]       rows_q;
    logic [ROW_CNT_W-1:0]       row_cnt;
    logic [ELEM_W-1:0]          elem_cnt;

    logic take;      // start accepted this cycle
    logic elem_inc;  // stage-2 scalar counted this cycle
    logic err_cond;
    logic v1, v2, any_v, both_v;

    assign v1     = result_stage_1_valid;
    assign v2     = result_stage_2_valid;
    assign any_v  = v1 | v2;
    assign both_v = v1 & v2;

    // Store always owns the port; loads only lose the single store cycle.
    assign ld_gnt = ld_req & ~store_result;

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        elem_inc = 1'b0;
        err_cond = 1'b0;
        case (state)
            IDLE: begin
                err_cond = any_v;
                if (start) begin
                    take     = 1'b1;
                    state_nx = (num_rows == '0) ? FIN : COLLECT;
                end
            end
            COLLECT: begin
                if (both_v) begin
                    err_cond = 1'b1;
                end else if (mode_q == MODE_RED) begin
                    if (v1) begin
                        err_cond = 1'b1;
                    end else if (v2) begin
                        elem_inc = 1'b1;
                        if (elem_cnt == ELEM_LAST) state_nx = STORE;
                    end
                end else begin
                    if (v2)      err_cond = 1'b1;
                    else if (v1) state_nx = STORE;
                end
            end
            STORE: begin
                // Anything arriving now is dropped by mem_stage.
                err_cond = any_v;
                state_nx = ((row_cnt + ROW_CNT_W'(1)) == rows_q) ? FIN : COLLECT;
            end
            FIN: begin
                err_cond = any_v;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= IDLE;
            mode_q       <= 1'b0;
            base_q       <= '0;
            rows_q       <= '0;
            row_cnt      <= '0;
            elem_cnt     <= '0;
            write_addr   <= '0;
            store_result <= 1'b0;
            pipe_stall   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state <= state_nx;
            if (take) begin
                mode_q   <= mode;
                base_q   <= base_addr;
                rows_q   <= num_rows;
                row_cnt  <= '0;
                elem_cnt <= '0;
            end
            if (elem_inc)
                elem_cnt <= (elem_cnt == ELEM_LAST) ? '0 : elem_cnt + ELEM_W'(1);
            // Address wraps naturally in DRAM_ADDR_WIDTH bits.
            if (state == COLLECT && state_nx == STORE)
                write_addr <= base_q + DRAM_ADDR_WIDTH'(row_cnt);
            if (state == STORE)
                row_cnt <= row_cnt + ROW_CNT_W'(1);
            err          <= (take ? 1'b0 : err) | err_cond;
            store_result <= (state_nx == STORE);
            pipe_stall   <= (state_nx == STORE);
            busy         <= (state_nx != IDLE);
            done         <= (state_nx == FIN);
        end
    end

endmodule

// File: tb/tb_wb_store_ctrl.sv
// Self-checking bench for wb_store_ctrl: directed scenarios plus randomized jobs
// checked cycle by cycle against a row/element-count reference model.
module tb_wb_store_ctrl;

    localparam int PE   = 4;
    localparam int AW   = 8;
    localparam int RW   = 16;
    localparam int AMOD = 1 << AW;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [RW-1:0] num_rows = '0;
    logic          s1 = 1'b0, s2 = 1'b0, ld_req = 1'b0;
    logic          ld_gnt, store_result, pipe_stall, busy, done, err;
    logic [AW-1:0] write_addr;

    wb_store_ctrl #(.PE_ELEMENTS(PE), .DMEM_DEPTH(1024), .ROW_CNT_W(RW)) dut (
        .clk(clk), .rstn(rstn), .start(start), .mode(mode), .base_addr(base_addr),
        .num_rows(num_rows), .result_stage_1_valid(s1), .result_stage_2_valid(s2),
        .ld_req(ld_req), .ld_gnt(ld_gnt), .store_result(store_result),
        .write_addr(write_addr), .pipe_stall(pipe_stall), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int errs = 0, checks = 0;
    int gnt_lows = 0;
    int st_log[$];

    // Reference model: job bookkeeping in plain integers.
    int m_active = 0, m_store = 0, m_done = 0, m_err = 0, m_addr = 0;
    int m_stored = 0, m_elems = 0, m_mode = 0, m_base = 0, m_rows = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0; m_store = 0; m_done = 0; m_err = 0; m_addr = 0;
        m_stored = 0; m_elems = 0; m_mode = 0; m_base = 0; m_rows = 0;
    endtask

    task automatic step(input logic v1, input logic v2, input logic st, input logic lr);
        int  n_store, n_done;
        bit  collecting, e;
        s1 = v1; s2 = v2; start = st; ld_req = lr;
        @(negedge clk);
        chk("store_result", store_result, m_store);
        chk("write_addr", write_addr, m_addr);
        chk("pipe_stall", pipe_stall, m_store);
        chk("busy", busy, m_active);
        chk("done", done, m_done);
        chk("err", err, m_err);
        chk("ld_gnt", ld_gnt, lr & (m_store == 0));
        if (store_result) st_log.push_back(int'(write_addr));
        if (lr && !ld_gnt) gnt_lows++;
        if (!rstn) begin
            model_reset();
        end else begin
            n_store = 0; n_done = 0;
            collecting = (m_active != 0) && (m_store == 0) && (m_done == 0);
            e = 0;
            if (v1 && v2) e = 1;
            if ((v1 || v2) && !collecting) e = 1;
            if (collecting && (m_mode != 0 ? v1 : v2)) e = 1;
            if (m_active == 0) begin
                if (st) begin
                    m_err = 0; m_mode = mode; m_base = base_addr; m_rows = num_rows;
                    m_stored = 0; m_elems = 0; m_active = 1;
                    if (num_rows == 0) n_done = 1;
                end
            end else if (m_store != 0) begin
                m_stored++;
                if (m_stored == m_rows) n_done = 1;
            end else if (m_done != 0) begin
                m_active = 0;
            end else if (!e && (v1 || v2)) begin
                if (m_mode == 0) begin
                    n_store = 1;
                end else begin
                    m_elems++;
                    if (m_elems == PE) begin m_elems = 0; n_store = 1; end
                end
                if (n_store != 0) m_addr = (m_base + m_stored) % AMOD;
            end
            if (e) m_err = 1;
            m_store = n_store; m_done = n_done;
        end
        @(posedge clk); #1;
    endtask

    task automatic run_idle(input int n, input logic lr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, lr);
    endtask

    task automatic launch(input logic md, input int b, input int rows, input logic lr);
        mode = md; base_addr = AW'(b); num_rows = RW'(rows);
        step(1'b0, 1'b0, 1'b1, lr);
    endtask

    // Finish a job by feeding valids only when the pipe is not stalled.
    task automatic drain(input logic lr);
        int cyc;
        cyc = 0;
        while (m_active != 0 && cyc < 200) begin
            if (m_store == 0 && m_done == 0) step(m_mode == 0, m_mode != 0, 1'b0, lr);
            else step(1'b0, 1'b0, 1'b0, lr);
            cyc++;
        end
        chk("drain_timeout", cyc >= 200, 0);
    endtask

    initial begin
        int cnt, r, cyc, lo;
        logic v1, v2, lr;

        rstn = 1'b0;
        run_idle(2, 1'b0);
        chk("rst_busy", busy, 0);
        chk("rst_addr", write_addr, 0);
        rstn = 1'b1;
        run_idle(1, 1'b0);

        // 1 + 4: VEC rows=3 base=10, ld_req held high throughout
        st_log.delete(); gnt_lows = 0;
        launch(1'b0, 10, 3, 1'b1);
        step(0, 0, 0, 1); step(1, 0, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);
        step(1, 0, 0, 1); step(0, 0, 0, 1); step(1, 0, 0, 1);
        run_idle(4, 1'b1);
        chk("t1_nstores", st_log.size(), 3);
        if (st_log.size() == 3) begin
            chk("t1_a0", st_log[0], 10); chk("t1_a1", st_log[1], 11); chk("t1_a2", st_log[2], 12);
        end
        chk("t1_err", err, 0);
        chk("t4_gnt_lows", gnt_lows, 3);

        // 2: RED rows=2, back-to-back scalars honouring stall
        st_log.delete();
        launch(1'b1, 40, 2, 1'b0);
        cnt = 0;
        while (cnt < 8) begin
            if (m_store != 0) step(0, 0, 0, 0);
            else begin step(0, 1, 0, 0); cnt++; end
        end
        run_idle(4, 1'b0);
        chk("t2_nstores", st_log.size(), 2);
        if (st_log.size() == 2) begin chk("t2_a0", st_log[0], 40); chk("t2_a1", st_log[1], 41); end
        chk("t2_err", err, 0);

        // 3: address wrap
        st_log.delete();
        launch(1'b0, 255, 2, 1'b0);
        drain(1'b0);
        run_idle(1, 1'b0);
        chk("t3_nstores", st_log.size(), 2);
        if (st_log.size() == 2) begin chk("t3_a0", st_log[0], 255); chk("t3_a1", st_log[1], 0); end

        // 5: error cases do not move the counts
        st_log.delete();
        launch(1'b0, 0, 2, 1'b0);
        step(1, 0, 0, 0);          // row 0 completes
        step(1, 0, 0, 0);          // valid during STORE
        chk("t5_err_stall", err, 1);
        step(0, 1, 0, 0);          // wrong type
        step(1, 1, 0, 0);          // simultaneous
        run_idle(2, 1'b0);
        chk("t5_nstores_mid", st_log.size(), 1);
        step(1, 0, 0, 0);
        run_idle(4, 1'b0);
        chk("t5_nstores", st_log.size(), 2);
        chk("t5_err_hold", err, 1);
        launch(1'b0, 0, 0, 1'b0);
        chk("t5_err_clr", err, 0);
        run_idle(2, 1'b0);

        // 6: zero rows, then reset mid-collect
        st_log.delete();
        launch(1'b1, 7, 0, 1'b0);
        chk("t6_done", done, 1);
        run_idle(3, 1'b0);
        chk("t6_nstores", st_log.size(), 0);
        launch(1'b1, 7, 3, 1'b0);
        step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
        rstn = 1'b0;
        step(0, 1, 0, 0);
        rstn = 1'b1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_stall", pipe_stall, 0);
        run_idle(3, 1'b0);
        chk("t6_rst_nostore", st_log.size(), 0);

        // Randomized jobs with injected errors, stray starts and occasional resets
        for (int job = 0; job < 150; job++) begin
            lr = logic'($urandom_range(0, 1));
            run_idle($urandom_range(0, 2), lr);
            if ($urandom_range(0, 9) == 0) step(1'b1, 1'b0, 1'b0, lr);   // stray valid in IDLE
            lo = $urandom_range(0, 4);
            launch(logic'($urandom_range(0, 1)), $urandom_range(0, AMOD - 1), lo, lr);
            cyc = 0;
            while (m_active != 0 && cyc < 300) begin
                r = $urandom_range(0, 99);
                v1 = 1'b0; v2 = 1'b0;
                if (r < 3) begin v1 = 1'b1; v2 = 1'b1; end
                else if (r < 6) begin if (m_mode != 0) v1 = 1'b1; else v2 = 1'b1; end
                else if (r < 60 && (m_store == 0 || r < 9)) begin
                    if (m_mode != 0) v2 = 1'b1; else v1 = 1'b1;
                end
                if ((job % 13) == 5 && cyc == 3) begin
                    rstn = 1'b0;
                    step(1'b0, 1'b0, 1'b0, lr);
                    rstn = 1'b1;
                end else if ($urandom_range(0, 29) == 0 && !v1 && !v2) begin
                    mode = logic'($urandom_range(0, 1));
                    base_addr = AW'($urandom_range(0, AMOD - 1));
                    num_rows = RW'($urandom_range(0, 4));
                    step(1'b0, 1'b0, 1'b1, lr);                        // ignored while busy
                end else begin
                    step(v1, v2, 1'b0, lr);
                end
                lr = logic'($urandom_range(0, 1));
                cyc++;
            end
            chk("rand_timeout", cyc >= 300, 0);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
